// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch defaults, the fetch FSM state type
// and the IF/ID record layout.
package cpu_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEF  = 16'h0000;
  localparam word_t PC_INC_DEF    = 16'd2;
  localparam word_t NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t nextpc;
    logic  valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction that returned while decode
// was stalled. Flush and unload both empty it; flush has priority over load.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  flush_i,
  input  word_t instr_i,
  input  word_t nextpc_i,
  output ifid_t entry_o
);

  logic  valid_q;
  word_t instr_q;
  word_t nextpc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; valid_q alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (load_i) begin
      instr_q  <= instr_i;
      nextpc_q <= nextpc_i;
    end
  end

  assign entry_o = '{instr: instr_q, nextpc: nextpc_q, valid: valid_q};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register and skid buffer.
// Optional macro FETCH_PERF_EN adds saturating FetchCount/BubbleCount outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t PC_INC    = PC_INC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  Stall,
  input  logic  Redirect,
  input  word_t TruePC,
  output logic  ImemReq,
  output word_t ImemAddr,
  input  logic  ImemAck,
  input  word_t ImemData,
  output word_t Instruct,
  output word_t NextPC,
`ifdef FETCH_PERF_EN
  output word_t FetchCount,
  output word_t BubbleCount,
`endif
  output logic  InstValid
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        addr_q, addr_d;
  logic         req_q, req_d;
  ifid_t        ifid_q, ifid_d;

  logic  skid_load, skid_unload, skid_flush;
  ifid_t skid_entry;
  logic  redir_ok;
  word_t pc_inc;

  assign redir_ok = Redirect && !Stall;
  assign pc_inc   = pc_q + PC_INC;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .instr_i  (ImemData),
    .nextpc_i (pc_inc),
    .entry_o  (skid_entry)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = redir_ok;

    // Unstalled decode takes a bubble unless a real instruction is loaded below.
    if (!Stall) begin
      ifid_d = '{instr: NOP_INSTR, nextpc: ifid_q.nextpc, valid: 1'b0};
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ImemAck) begin
          if (redir_ok) begin
            pc_d = TruePC;
          end else begin
            pc_d = pc_inc;
            if (Stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              ifid_d = '{instr: ImemData, nextpc: pc_inc, valid: 1'b1};
            end
          end
        end else if (redir_ok) begin
          pc_d    = TruePC;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (!Stall) begin
          if (Redirect) begin
            pc_d = TruePC;
          end else begin
            ifid_d      = skid_entry;
            skid_unload = 1'b1;
          end
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redir_ok) pc_d = TruePC;
        if (ImemAck) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // The stale request in DRAIN must keep its address until the memory acks it.
    req_d  = (state_d == REQ) || (state_d == DRAIN);
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      ifid_q  <= '{instr: NOP_INSTR, nextpc: 16'h0000, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ifid_q  <= ifid_d;
    end
  end

  assign ImemReq   = req_q;
  assign ImemAddr  = addr_q;
  assign Instruct  = ifid_q.instr;
  assign NextPC    = ifid_q.nextpc;
  assign InstValid = ifid_q.valid;

`ifdef FETCH_PERF_EN
  word_t fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else if (!Stall) begin
      if (ifid_d.valid && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (!ifid_d.valid && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table-driven zero-wait/stall/redirect vectors
// plus hand sequences for delayed acks, DRAIN redirects, PC wrap and mid-request reset.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  Stall, Redirect;
  word_t TruePC;
  logic  ImemReq;
  word_t ImemAddr;
  logic  ImemAck;
  word_t ImemData;
  word_t Instruct, NextPC;
  logic  InstValid;
`ifdef FETCH_PERF_EN
  word_t FetchCount, BubbleCount;
`endif

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .TruePC     (TruePC),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemData   (ImemData),
    .Instruct   (Instruct),
    .NextPC     (NextPC),
`ifdef FETCH_PERF_EN
    .FetchCount (FetchCount),
    .BubbleCount(BubbleCount),
`endif
    .InstValid  (InstValid)
  );

  function automatic word_t mem(input word_t a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: acks after ack_delay waiting cycles of an asserted request.
  always @(posedge clk) begin
    if (rst || !ImemReq || ImemAck) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign ImemAck  = ImemReq && (wait_cnt >= ack_delay);
  assign ImemData = ImemAck ? mem(ImemAddr) : 16'hBAD0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic req, input word_t addr,
                            input logic v, input word_t instr, input word_t np);
    check({name, ".ImemReq"}, 16'(ImemReq), 16'(req));
    if (req) check({name, ".ImemAddr"}, ImemAddr, addr);
    check({name, ".InstValid"}, 16'(InstValid), 16'(v));
    check({name, ".Instruct"}, Instruct, instr);
    check({name, ".NextPC"}, NextPC, np);
  endtask

  task automatic step(input logic s, input logic r, input word_t t);
    Stall    = s;
    Redirect = r;
    TruePC   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst      = 1'b1;
    Stall    = 1'b0;
    Redirect = 1'b0;
    TruePC   = 16'h0000;
    @(posedge clk);
    #1;
    expect_out(name, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
  endtask

  typedef struct {
    logic  stall;
    logic  redir;
    word_t tpc;
    logic  req;
    word_t addr;
    logic  valid;
    word_t instr;
    word_t np;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Zero-wait memory: streaming, 4-cycle stall into HOLD, redirect on ack,
    // redirect ignored while stalled, redirect out of HOLD.
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'hC3A5, 16'h0002};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'hC3A7, 16'h0004};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'hC3A1, 16'h0006};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC3A1, 16'h0006};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC3A1, 16'h0006};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC3A1, 16'h0006};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC3A1, 16'h0006};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'hC3A3, 16'h0008};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'hC3AD, 16'h000A};
    vecs[10] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h000A};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'hC3E5, 16'h0042};
    vecs[12] = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 16'hC3E5, 16'h0042};
    vecs[13] = '{1'b0, 1'b1, 16'h0080, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0042};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0082, 1'b1, 16'hC325, 16'h0082};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0084, 1'b1, 16'hC327, 16'h0084};

    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; TruePC = 16'h0000;

    ack_delay = 0;
    do_reset("reset0");
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].stall, vecs[i].redir, vecs[i].tpc);
      expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                 vecs[i].instr, vecs[i].np);
    end

    // 3-cycle ack latency: address held, three bubbles between instructions.
    ack_delay = 3;
    do_reset("reset_dly");
    step(1'b0, 1'b0, 16'h0000);
    expect_out("dly_req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'h0000);
      expect_out($sformatf("dly_wait0_%0d", k), 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    end
    step(1'b0, 1'b0, 16'h0000);
    expect_out("dly_first", 1'b1, 16'h0002, 1'b1, 16'hC3A5, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'h0000);
      expect_out($sformatf("dly_wait1_%0d", k), 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0002);
    end
    step(1'b0, 1'b0, 16'h0000);
    expect_out("dly_second", 1'b1, 16'h0004, 1'b1, 16'hC3A7, 16'h0004);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("dly_wait2", 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0004);
    do_reset("reset_midreq");
    step(1'b0, 1'b0, 16'h0000);
    expect_out("post_reset_req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // Redirect with a request outstanding: old data drained and discarded.
    ack_delay = 2;
    do_reset("reset_drain");
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 16'h0040);
    expect_out("drain_enter", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_wait", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_ack", 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_new_w0", 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_new_w1", 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain_target", 1'b1, 16'h0042, 1'b1, 16'hC3E5, 16'h0042);

    // Second redirect while draining: only the last target is fetched.
    do_reset("reset_drain2");
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0040);
    expect_out("drain2_enter", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 16'h0060);
    expect_out("drain2_redir", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain2_ack", 1'b1, 16'h0060, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("drain2_target", 1'b1, 16'h0062, 1'b1, 16'hC3C5, 16'h0062);

    // PC wrap at 16'hFFFE.
    ack_delay = 0;
    do_reset("reset_wrap");
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFE);
    expect_out("wrap_redir", 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("wrap_fetch", 1'b1, 16'h0000, 1'b1, 16'h3C5B, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_out("wrap_next", 1'b1, 16'h0002, 1'b1, 16'hC3A5, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
